// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, write-allocate cache controller with on-chip tag/valid/data
// storage and an internal memory-latency counter. Optional hit/miss counters: CACHE_STATS_EN.
module cache_ctrl_dm #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int LINES   = 16,
  parameter int MEM_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          strobe,
  input  logic          rw,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          flush,
  output logic [DW-1:0] rdata,
  output logic          rdy,
  output logic          busy,
  output logic          mstrobe,
  output logic          mrw,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mwdata,
  input  logic [DW-1:0] mrdata
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt
`endif
);

  localparam int IW = $clog2(LINES);
  localparam int TW = AW - IW;
  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_DONE,
    S_FLUSH
  } state_t;

  state_t          state_q, state_d;
  logic            req_rw_q;
  logic [AW-1:0]   req_addr_q;
  logic [DW-1:0]   req_wdata_q;
  logic [CW-1:0]   cnt_q;
  logic [LINES-1:0] valid_q;

  logic [TW-1:0]   tag_mem  [LINES];
  logic [DW-1:0]   data_mem [LINES];

  logic [IW-1:0]   idx;
  logic [TW-1:0]   tag;
  logic            hit;
  logic            read_hit;
  logic            fill;
  logic [DW-1:0]   fill_data;

  assign idx       = req_addr_q[IW-1:0];
  assign tag       = req_addr_q[AW-1:IW];
  assign hit       = valid_q[idx] && (tag_mem[idx] == tag);
  assign read_hit  = !req_rw_q && hit;
  assign fill      = (state_q == S_MEM_WAIT) && (cnt_q == CW'(1));
  assign fill_data = req_rw_q ? req_wdata_q : mrdata;

  // Status strobes decode straight from the state, so an async reset clears them at once.
  assign rdy     = (state_q == S_DONE);
  assign busy    = (state_q != S_IDLE);
  assign mstrobe = (state_q == S_MEM_REQ);

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (flush)       state_d = S_FLUSH;
        else if (strobe) state_d = S_LOOKUP;
      end
      S_LOOKUP:   state_d = read_hit ? S_DONE : S_MEM_REQ;
      S_MEM_REQ:  state_d = S_MEM_WAIT;
      S_MEM_WAIT: if (fill) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      S_FLUSH:    state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_rw_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      cnt_q       <= '0;
      valid_q     <= '0;
      mrw         <= 1'b0;
      maddr       <= '0;
      mwdata      <= '0;
      rdata       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && !flush && strobe) begin
        req_rw_q    <= rw;
        req_addr_q  <= addr;
        req_wdata_q <= wdata;
      end
      case (state_q)
        S_LOOKUP: begin
          if (read_hit) begin
            rdata <= data_mem[idx];
          end else begin
            mrw    <= req_rw_q;
            maddr  <= req_addr_q;
            mwdata <= req_wdata_q;
          end
        end
        S_MEM_REQ:  cnt_q <= CW'(MEM_LAT);
        S_MEM_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (fill) begin
            valid_q[idx] <= 1'b1;
            rdata        <= fill_data;
          end
        end
        S_FLUSH:    valid_q <= '0;
        default: ;
      endcase
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= fill_data;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (hit) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
